multi_alarm_ctrl: RTL
=====================

Name: multi_alarm_ctrl

Overview:
Parametrised alarm engine for the clock datapath, running in the clk256 domain. It holds NUM_ALARMS BCD HHMM alarm registers, each with its own enable bit. It compares them against the counter's current time on each minute tick and runs a ringing/snooze state machine with a bounded snooze count and an auto-off timeout. It replaces the single-alarm register and exports ring/beep status and the selected alarm for display.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..16); IW = max(1, clog2(NUM_ALARMS)) is a derived localparam.
SNOOZE_MIN, 9, minutes per snooze period (1..63).
MAX_SNOOZE, 3, snoozes allowed per ring event; a further snooze acts as alarm_off.
RING_TIMEOUT_MIN, 30, minutes of unanswered ringing before auto-off (1..63).
BEEP_HALF, 64, clk256 cycles per beep half-period (2 Hz at 256 Hz).

Ports:
clk256  in  1  system clock for this block (256 Hz tick domain)
reset  in  1  asynchronous, active-high reset
one_minute  in  1  single-cycle minute tick from TIME_GEN
current_time  in  16  BCD HHMM from the clock counter; updates on the one_minute cycle
load_alarm  in  1  single-cycle write strobe
alarm_sel  in  IW  slot addressed by load/enable writes and by display readback
new_alarm_time  in  16  BCD HHMM to write
set_enable  in  1  single-cycle strobe that writes enable_val to slot alarm_sel
enable_val  in  1  enable value for the addressed slot
snooze  in  1  single-cycle pulse (edge_to_pulse output)
alarm_off  in  1  single-cycle pulse
sel_alarm_time  out  16  registered time of slot alarm_sel
sel_enabled  out  1  registered enable of slot alarm_sel
ringing  out  1  high in RING state
beep  out  1  ringing gated by beep square wave
snoozing  out  1  high in SNOOZE state
active_idx  out  IW  slot that triggered the current event
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (asynchronous): all slots 0000, all enables 0, state IDLE, all counters 0, every output 0.
- Writes:
  - load_alarm with valid BCD (hours 00-23, minutes 00-59, each nibble 0-9) writes the slot on the next edge.
  - An invalid load leaves the slot unchanged and pulses load_err for 1 cycle.
  - set_enable writes the enable bit. load_alarm and set_enable on the same cycle both apply.
  - Writes never change the FSM state, including writes to the slot that is currently ringing.
- Readback: sel_alarm_time and sel_enabled are registered, with 1-cycle latency from an alarm_sel or data change.
- Match:
  - one_minute is delayed 1 cycle to tick_d. Matching is evaluated only when tick_d=1, against the updated current_time.
  - A slot matches if it is enabled and its time equals current_time.
  - If several slots match, the lowest index wins. Matches are ignored outside IDLE.
- FSM:
  - IDLE: on a match, go to RING on the next edge; active_idx = matching slot; snooze_cnt=0; ring_min=0.
  - RING:
    - alarm_off goes to IDLE.
    - snooze with snooze_cnt<MAX_SNOOZE goes to SNOOZE, snooze_cnt+1, snz_min=SNOOZE_MIN.
    - snooze with snooze_cnt==MAX_SNOOZE goes to IDLE.
    - Each one_minute increments ring_min; when ring_min reaches RING_TIMEOUT_MIN, go to IDLE.
  - SNOOZE:
    - alarm_off goes to IDLE.
    - Each one_minute decrements snz_min; on the decrement to 0, go to RING with ring_min=0.
    - snooze is ignored.
  - Priority when pulses coincide: reset > alarm_off > snooze > minute events.
  - Disabling the active slot ends neither RING nor SNOOZE.
- Outputs:
  - ringing=(state==RING). snoozing=(state==SNOOZE). active_idx holds its value after returning to IDLE.
  - beep: a counter free-runs only in RING and clears on entry to RING. beep is 1 for the first BEEP_HALF cycles, then 0 for BEEP_HALF cycles, and repeats.
- Mid-operation reset returns everything to the reset values immediately.

Test Plan:
- Reset, write slot 2=0730 with enable=1, current_time 0729→0730 with a one_minute tick -> ringing=1 two cycles after the tick, active_idx=2, beep high for 64 cycles then low for 64.
- Slots 1 and 3 both =1200 and enabled, match -> active_idx=1. Repeat with slot 1 disabled -> active_idx=3 (slot 3).
- RING, then snooze -> snoozing=1. After 9 one_minute ticks -> ringing=1. After the 4th snooze (MAX_SNOOZE=3) -> IDLE, ringing=0.
- RING with no input for 30 one_minute ticks -> IDLE on the 30th. snooze and alarm_off on the same cycle -> IDLE.
- load_alarm with 2460, then 1275 -> load_err pulses for 1 cycle each, slot unchanged. 2359 -> accepted, readback 2359 one cycle later.
- Assert reset during SNOOZE -> outputs 0 asynchronously. A match on an enabled slot while in RING -> ignored, active_idx unchanged.

Source files
------------

// File: rtl/multi_alarm_ctrl_if.sv
// multi_alarm_ctrl_if
//   Configuration and readback bus for the multi-alarm engine.
//   master (controller side) drives:
//     load_alarm      single-cycle write strobe for an alarm time
//     alarm_sel       slot addressed by writes and by readback
//     new_alarm_time  BCD HHMM to write
//     set_enable      single-cycle strobe writing enable_val to slot alarm_sel
//     enable_val      enable value for the addressed slot
//   slave (alarm engine) returns:
//     sel_alarm_time  registered time of slot alarm_sel
//     sel_enabled     registered enable of slot alarm_sel
//     load_err        one-cycle pulse when a load carried invalid BCD
interface multi_alarm_ctrl_if #(
  parameter int NUM_ALARMS = 4
);
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic          load_alarm;
  logic [IW-1:0] alarm_sel;
  logic [15:0]   new_alarm_time;
  logic          set_enable;
  logic          enable_val;
  logic [15:0]   sel_alarm_time;
  logic          sel_enabled;
  logic          load_err;

  modport master (
    output load_alarm, alarm_sel, new_alarm_time, set_enable, enable_val,
    input  sel_alarm_time, sel_enabled, load_err
  );

  modport slave (
    input  load_alarm, alarm_sel, new_alarm_time, set_enable, enable_val,
    output sel_alarm_time, sel_enabled, load_err
  );
endinterface

// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl
//   Alarm engine in the clk256 domain. Holds NUM_ALARMS BCD HHMM alarm slots
//   with individual enables, compares them with the clock counter on every
//   minute tick and runs an IDLE/RING/SNOOZE state machine with a bounded
//   snooze count, an auto-off timeout and a 2 Hz beep gate.
//   Ports:
//     clk256        256 Hz block clock
//     reset         asynchronous, active-high reset
//     one_minute    single-cycle minute tick
//     current_time  BCD HHMM from the clock counter
//     snooze        single-cycle snooze pulse
//     alarm_off     single-cycle alarm-off pulse
//     cfg           slot write/enable/readback bus (slave side)
//     ringing       high while in RING
//     beep          ringing gated by the beep square wave
//     snoozing      high while in SNOOZE
//     active_idx    slot that triggered the current/last ring event
module multi_alarm_ctrl #(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 9,
  parameter int MAX_SNOOZE       = 3,
  parameter int RING_TIMEOUT_MIN = 30,
  parameter int BEEP_HALF        = 64,
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                     clk256,
  input  logic                     reset,
  input  logic                     one_minute,
  input  logic [15:0]              current_time,
  input  logic                     snooze,
  input  logic                     alarm_off,
  multi_alarm_ctrl_if.slave        cfg,
  output logic                     ringing,
  output logic                     beep,
  output logic                     snoozing,
  output logic [IW-1:0]            active_idx
);

  localparam int SCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int BW  = $clog2(2 * BEEP_HALF);

  localparam logic [SCW-1:0] SNOOZE_LIMIT  = SCW'(MAX_SNOOZE);
  localparam logic [5:0]     SNOOZE_START  = 6'(SNOOZE_MIN);
  localparam logic [5:0]     TIMEOUT_LAST  = 6'(RING_TIMEOUT_MIN - 1);
  localparam logic [BW-1:0]  BEEP_HALF_VAL = BW'(BEEP_HALF);
  localparam logic [BW-1:0]  BEEP_LAST     = BW'(2 * BEEP_HALF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     alarm_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alarm_en;
  logic            tick_d;
  logic [IW-1:0]   active_idx_nxt;
  logic [SCW-1:0]  snooze_cnt, snooze_cnt_nxt;
  logic [5:0]      ring_min, ring_min_nxt;
  logic [5:0]      snz_min, snz_min_nxt;
  logic [BW-1:0]   beep_cnt, beep_cnt_nxt;

  logic            load_valid;
  logic            sel_in_range;
  logic            match_found;
  logic [IW-1:0]   match_idx;

  // Hours 00-23 and minutes 00-59 with every nibble a legal BCD digit.
  always_comb begin
    load_valid = 1'b1;
    if (cfg.new_alarm_time[15:12] > 4'd2)                                    load_valid = 1'b0;
    if (cfg.new_alarm_time[11:8]  > 4'd9)                                    load_valid = 1'b0;
    if (cfg.new_alarm_time[15:12] == 4'd2 && cfg.new_alarm_time[11:8] > 4'd3) load_valid = 1'b0;
    if (cfg.new_alarm_time[7:4]   > 4'd5)                                    load_valid = 1'b0;
    if (cfg.new_alarm_time[3:0]   > 4'd9)                                    load_valid = 1'b0;
  end

  assign sel_in_range = (int'(cfg.alarm_sel) < NUM_ALARMS);

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_en[i] && (alarm_time[i] == current_time)) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
    end
  end

  // Slot storage, write error pulse and registered readback.
  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) alarm_time[i] <= 16'h0000;
      alarm_en           <= '0;
      cfg.load_err       <= 1'b0;
      cfg.sel_alarm_time <= 16'h0000;
      cfg.sel_enabled    <= 1'b0;
    end else begin
      cfg.load_err <= cfg.load_alarm && !load_valid;
      if (cfg.load_alarm && load_valid && sel_in_range)
        alarm_time[cfg.alarm_sel] <= cfg.new_alarm_time;
      if (cfg.set_enable && sel_in_range)
        alarm_en[cfg.alarm_sel] <= cfg.enable_val;
      cfg.sel_alarm_time <= sel_in_range ? alarm_time[cfg.alarm_sel] : 16'h0000;
      cfg.sel_enabled    <= sel_in_range ? alarm_en[cfg.alarm_sel] : 1'b0;
    end
  end

  // State and counter registers; the minute tick is delayed one cycle so the
  // match sees the counter's updated time.
  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick_d     <= 1'b0;
      active_idx <= '0;
      snooze_cnt <= '0;
      ring_min   <= '0;
      snz_min    <= '0;
      beep_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      tick_d     <= one_minute;
      active_idx <= active_idx_nxt;
      snooze_cnt <= snooze_cnt_nxt;
      ring_min   <= ring_min_nxt;
      snz_min    <= snz_min_nxt;
      beep_cnt   <= beep_cnt_nxt;
    end
  end

  // Next-state logic. Within each state alarm_off beats snooze, which beats
  // the minute tick.
  always_comb begin
    state_nxt      = state;
    active_idx_nxt = active_idx;
    snooze_cnt_nxt = snooze_cnt;
    ring_min_nxt   = ring_min;
    snz_min_nxt    = snz_min;
    beep_cnt_nxt   = '0;

    case (state)
      IDLE: begin
        if (tick_d && match_found) begin
          state_nxt      = RING;
          active_idx_nxt = match_idx;
          snooze_cnt_nxt = '0;
          ring_min_nxt   = '0;
        end
      end
      RING: begin
        if (alarm_off) begin
          state_nxt = IDLE;
        end else if (snooze) begin
          if (snooze_cnt == SNOOZE_LIMIT) begin
            state_nxt = IDLE;
          end else begin
            state_nxt      = SNOOZE;
            snooze_cnt_nxt = snooze_cnt + 1'b1;
            snz_min_nxt    = SNOOZE_START;
          end
        end else if (one_minute) begin
          if (ring_min == TIMEOUT_LAST) state_nxt = IDLE;
          else                          ring_min_nxt = ring_min + 1'b1;
        end
      end
      SNOOZE: begin
        if (alarm_off) begin
          state_nxt = IDLE;
        end else if (one_minute) begin
          if (snz_min == 6'd1) begin
            state_nxt    = RING;
            ring_min_nxt = '0;
            snz_min_nxt  = '0;
          end else begin
            snz_min_nxt = snz_min - 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The beep phase counter only runs while staying in RING, so every entry
    // into RING starts with the audible half-period.
    if (state == RING && state_nxt == RING)
      beep_cnt_nxt = (beep_cnt == BEEP_LAST) ? '0 : beep_cnt + 1'b1;
  end

  assign ringing  = (state == RING);
  assign snoozing = (state == SNOOZE);
  assign beep     = ringing && (beep_cnt < BEEP_HALF_VAL);

endmodule
